// File: rtl/fp_addsub_iter_if.sv
// Handshake and operand/result bundle for the iterative FP adder/subtractor.
interface fp_addsub_iter_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         add_sub_not;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         overflow;
  logic         underflow;
  logic         inexact;
  logic         invalid;

  modport master (
    output in_valid, a, b, add_sub_not, out_ready,
    input  in_ready, out_valid, result, overflow, underflow, inexact, invalid
  );

  modport slave (
    input  in_valid, a, b, add_sub_not, out_ready,
    output in_ready, out_valid, result, overflow, underflow, inexact, invalid
  );
endinterface

// File: rtl/fp_addsub_iter.sv
// Iterative IEEE-style floating-point add/subtract, one operation in flight.
//
//   state | meaning
//   IDLE  | ready for operands; specials resolve straight to DONE
//   ALIGN | right-shift smaller mantissa one bit per cycle, collecting sticky
//   ADD   | add or subtract aligned magnitudes
//   NORM  | renormalise: one right shift on carry, else left shifts to hidden bit
//   ROUND | round-to-nearest-even, range check, build result word
//   DONE  | hold result until consumer takes it
module fp_addsub_iter #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input logic clk,
  input logic rst,
  fp_addsub_iter_if.slave bus
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int MW = MAN_W + 1;       // mantissa with hidden bit
  localparam int XW = MW + 3;          // plus guard/round/sticky
  localparam int SW = XW + 1;          // plus carry-out
  localparam int EW = EXP_W + 2;       // signed exponent with headroom
  localparam int CW = $clog2(MAN_W + 4);

  localparam logic [EXP_W-1:0]        DMAX   = EXP_W'(MAN_W + 3);
  localparam logic [CW-1:0]           DMAX_C = CW'(MAN_W + 3);
  localparam logic signed [EW-1:0]    E_ONE  = EW'(1);
  localparam logic signed [EW-1:0]    E_INF  = {2'b00, {EXP_W{1'b1}}};
  localparam logic [W-1:0]            QNAN   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, ROUND, DONE} state_t;
  state_t state, state_nx;

  logic                    sign_r, sub_r;
  logic signed [EW-1:0]    exp_r;
  logic [MW-1:0]           big_r;
  logic [XW-1:0]           sm_r;
  logic [SW-1:0]           mant_r;
  logic [CW-1:0]           cnt_r;
  logic [W-1:0]            result_r;
  logic                    ovf_r, unf_r, inx_r, inv_r;

  // operand decode; b is sign-flipped for subtraction
  logic             sa, sb;
  logic [EXP_W-1:0] ea, eb, diff;
  logic [MAN_W-1:0] fa, fb;
  logic             a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, special, a_ge;
  logic [CW-1:0]    d_ld;

  assign sa     = bus.a[W-1];
  assign sb     = bus.b[W-1] ^ ~bus.add_sub_not;
  assign ea     = bus.a[W-2 -: EXP_W];
  assign eb     = bus.b[W-2 -: EXP_W];
  assign fa     = bus.a[MAN_W-1:0];
  assign fb     = bus.b[MAN_W-1:0];
  assign a_nan  = (&ea) && (|fa);
  assign b_nan  = (&eb) && (|fb);
  assign a_inf  = (&ea) && !(|fa);
  assign b_inf  = (&eb) && !(|fb);
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign special = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;
  assign a_ge   = {ea, fa} >= {eb, fb};
  assign diff   = a_ge ? (ea - eb) : (eb - ea);
  assign d_ld   = (diff > DMAX) ? DMAX_C : CW'(diff);

  // special-case result, priority NaN > Inf > zeros
  logic [W-1:0] spec_res;
  logic         spec_inv;
  always_comb begin
    spec_res = '0;
    spec_inv = 1'b0;
    if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
      spec_res = QNAN;
      spec_inv = 1'b1;
    end else if (a_inf) begin
      spec_res = {sa, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (b_inf) begin
      spec_res = {sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (a_zero && b_zero) begin
      spec_res = {sa & sb, {(W-1){1'b0}}};
    end else if (a_zero) begin
      spec_res = {sb, eb, fb};
    end else begin
      spec_res = bus.a;
    end
  end

  // magnitude add/subtract; larger operand is always in big_r
  logic [SW-1:0] sum_c;
  logic          sum_zero;
  assign sum_c    = sub_r ? ({1'b0, big_r, 3'b000} - {1'b0, sm_r})
                          : ({1'b0, big_r, 3'b000} + {1'b0, sm_r});
  assign sum_zero = (sum_c == '0);

  // nearest-even rounding on the normalised mantissa
  logic                 rup;
  logic [MW:0]          rsum;
  logic signed [EW-1:0] rexp;
  logic [MAN_W-1:0]     rfrac;
  assign rup   = mant_r[2] & (mant_r[1] | mant_r[0] | mant_r[3]);
  assign rsum  = {1'b0, mant_r[XW-1:3]} + {{MW{1'b0}}, rup};
  assign rexp  = rsum[MW] ? (exp_r + E_ONE) : exp_r;
  assign rfrac = rsum[MW] ? rsum[MAN_W:1] : rsum[MAN_W-1:0];

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // next-state decode
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (bus.in_valid) state_nx = special ? DONE : ALIGN;
      ALIGN: if (cnt_r == '0) state_nx = ADD;
      ADD:   state_nx = sum_zero ? DONE : NORM;
      NORM:  if (mant_r[SW-1] || mant_r[XW-1]) state_nx = ROUND;
      ROUND: state_nx = DONE;
      DONE:  if (bus.out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // handshake outputs and result drive
  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.out_valid = (state == DONE);
    bus.result    = result_r;
    bus.overflow  = ovf_r;
    bus.underflow = unf_r;
    bus.inexact   = inx_r;
    bus.invalid   = inv_r;
  end

  // datapath: load, align, add, normalise, round
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sign_r <= 1'b0; sub_r <= 1'b0; exp_r <= '0; big_r <= '0; sm_r <= '0;
      mant_r <= '0; cnt_r <= '0; result_r <= '0;
      ovf_r <= 1'b0; unf_r <= 1'b0; inx_r <= 1'b0; inv_r <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          ovf_r <= 1'b0; unf_r <= 1'b0; inx_r <= 1'b0; inv_r <= 1'b0;
          if (special) begin
            result_r <= spec_res;
            inv_r    <= spec_inv;
          end else begin
            sign_r <= a_ge ? sa : sb;
            sub_r  <= sa ^ sb;
            exp_r  <= $signed({2'b00, (a_ge ? ea : eb)});
            big_r  <= a_ge ? {1'b1, fa} : {1'b1, fb};
            sm_r   <= {(a_ge ? {1'b1, fb} : {1'b1, fa}), 3'b000};
            cnt_r  <= d_ld;
          end
        end
        ALIGN: if (cnt_r != '0) begin
          sm_r  <= {1'b0, sm_r[XW-1:2], sm_r[1] | sm_r[0]};
          cnt_r <= cnt_r - 1'b1;
        end
        ADD: begin
          mant_r <= sum_c;
          if (sum_zero) result_r <= '0;
        end
        NORM: begin
          if (mant_r[SW-1]) begin
            mant_r <= {1'b0, mant_r[SW-1:2], mant_r[1] | mant_r[0]};
            exp_r  <= exp_r + E_ONE;
          end else if (!mant_r[XW-1]) begin
            mant_r <= {mant_r[SW-2:0], 1'b0};
            exp_r  <= exp_r - E_ONE;
          end
        end
        ROUND: begin
          inx_r <= |mant_r[2:0];
          if (rexp >= E_INF) begin
            result_r <= {sign_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            ovf_r    <= 1'b1;
            inx_r    <= 1'b1;
          end else if (rexp < E_ONE) begin
            result_r <= {sign_r, {(W-1){1'b0}}};
            unf_r    <= 1'b1;
            inx_r    <= 1'b1;
          end else begin
            result_r <= {sign_r, rexp[EXP_W-1:0], rfrac};
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_addsub_iter.sv
// Directed-vector bench for fp_addsub_iter (single precision).
module tb_fp_addsub_iter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fp_addsub_iter_if #(.EXP_W(8), .MAN_W(23)) bus();
  fp_addsub_iter #(.EXP_W(8), .MAN_W(23)) dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // flg = {overflow, underflow, inexact, invalid}
  // lat = rising edges after the accept edge before out_valid is seen
  //       (specials are already valid right after the accept edge)
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
    logic [31:0] res;
    logic [3:0]  flg;
    int          lat;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];

  task automatic wait_result(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic do_op(input int idx, input vec_t v);
    int lat;
    @(negedge clk);
    bus.a = v.a; bus.b = v.b; bus.add_sub_not = v.op;
    bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    chk($sformatf("v%0d in_ready", idx), 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    wait_result(lat);
    chk($sformatf("v%0d latency", idx), 64'(lat), 64'(v.lat));
    chk($sformatf("v%0d result", idx), 64'(bus.result), 64'(v.res));
    chk($sformatf("v%0d flags", idx),
        64'({bus.overflow, bus.underflow, bus.inexact, bus.invalid}), 64'(v.flg));
    @(negedge clk); bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk($sformatf("v%0d released", idx), 64'({bus.out_valid, bus.in_ready}), 64'b01);
  endtask

  initial begin
    int lat;
    logic [31:0] held;
    //                a            b            op   result       flg      lat
    vecs[0]  = '{32'h3F800000, 32'h3F800000, 1'b1, 32'h40000000, 4'b0000, 4};
    vecs[1]  = '{32'h3F800000, 32'h33800000, 1'b1, 32'h3F800000, 4'b0010, 28};
    vecs[2]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b1, 32'h7F800000, 4'b1010, 4};
    vecs[3]  = '{32'h7F800000, 32'h7F800000, 1'b0, 32'h7FC00000, 4'b0001, 0};
    vecs[4]  = '{32'h00800000, 32'h00800001, 1'b0, 32'h80000000, 4'b0110, 27};
    vecs[5]  = '{32'h40400000, 32'h40400000, 1'b0, 32'h00000000, 4'b0000, 2};
    vecs[6]  = '{32'h40000000, 32'h3F800000, 1'b0, 32'h3F800000, 4'b0000, 6};
    vecs[7]  = '{32'h3F800000, 32'hBF800000, 1'b1, 32'h00000000, 4'b0000, 2};
    vecs[8]  = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h7FC00000, 4'b0001, 0};
    vecs[9]  = '{32'hFF800000, 32'h3F800000, 1'b1, 32'hFF800000, 4'b0000, 0};
    vecs[10] = '{32'h00000000, 32'h3F800000, 1'b0, 32'hBF800000, 4'b0000, 0};
    vecs[11] = '{32'h80000000, 32'h80000000, 1'b1, 32'h80000000, 4'b0000, 0};
    vecs[12] = '{32'h80000000, 32'h00000000, 1'b0, 32'h80000000, 4'b0000, 0};
    vecs[13] = '{32'h00000001, 32'h80000000, 1'b1, 32'h00000000, 4'b0000, 0};
    vecs[14] = '{32'h3F800000, 32'h00000000, 1'b0, 32'h3F800000, 4'b0000, 0};
    vecs[15] = '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7F800000, 4'b0000, 0};
    vecs[16] = '{32'h3FC00000, 32'h40100000, 1'b1, 32'h40700000, 4'b0000, 5};
    vecs[17] = '{32'h3F800001, 32'h33800000, 1'b1, 32'h3F800002, 4'b0010, 28};
    vecs[18] = '{32'h3F800000, 32'h00800000, 1'b1, 32'h3F800000, 4'b0010, 30};
    vecs[19] = '{32'h3F800000, 32'h40000000, 1'b0, 32'hBF800000, 4'b0000, 6};
    vecs[20] = '{32'h3FFFFFFF, 32'h33800000, 1'b1, 32'h40000000, 4'b0010, 28};

    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.add_sub_not = 1'b1; bus.out_ready = 1'b0;
    #1;
    chk("reset state", 64'({bus.in_ready, bus.out_valid, bus.result,
                            bus.overflow, bus.underflow, bus.inexact, bus.invalid}),
        64'({1'b1, 1'b0, 32'h0, 4'b0000}));
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < NV; i++) do_op(i, vecs[i]);

    // backpressure: DONE held 5 cycles, then same-edge out_ready/in_valid
    @(negedge clk);
    bus.a = 32'h3F800000; bus.b = 32'h3F800000; bus.add_sub_not = 1'b1; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    wait_result(lat);
    chk("bp latency", 64'(lat), 64'd4);
    held = bus.result;
    chk("bp first result", 64'(held), 64'h40000000);
    bus.a = 32'h40400000; bus.b = 32'h40400000; bus.add_sub_not = 1'b0; bus.in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk($sformatf("bp hold%0d", k),
          64'({bus.out_valid, bus.in_ready, bus.result}), 64'({1'b1, 1'b0, 32'h40000000}));
    end
    @(negedge clk); bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("bp release", 64'({bus.out_valid, bus.in_ready}), 64'b01);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("bp accepted late", 64'(bus.in_ready), 64'd0);
    wait_result(lat);
    chk("bp zero latency", 64'(lat), 64'd2);
    chk("bp zero result", 64'(bus.result), 64'h0);
    @(negedge clk); bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;

    // reset pulsed while aligning a d=24 operation
    @(negedge clk);
    bus.a = 32'h3F800000; bus.b = 32'h33800000; bus.add_sub_not = 1'b1; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst in align", 64'({bus.out_valid, bus.in_ready, bus.result,
                             bus.overflow, bus.underflow, bus.inexact, bus.invalid}),
        64'({1'b0, 1'b1, 32'h0, 4'b0000}));
    @(negedge clk); rst = 1'b0;
    lat = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (bus.out_valid || !bus.in_ready) lat++;
    end
    chk("no output after rst", 64'(lat), 64'd0);

    do_op(99, vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fp_addsub_iter.md
FP_ADDSUB_ITER -- requirements
Module: fp_addsub_iter

Interface
REQ-001 SHALL have parameter EXP_W, default 8, meaning exponent field width.
REQ-002 SHALL have parameter MAN_W, default 23, meaning stored fraction width; word width W = 1+EXP_W+MAN_W.
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  operand set present.
REQ-006 SHALL have port in_ready  output  1  block can accept operands.
REQ-007 SHALL have ports a and b  input  W each  IEEE-style operands, sign at MSB.
REQ-008 SHALL have port add_sub_not  input  1  1 = a+b, 0 = a-b.
REQ-009 SHALL have port out_valid  output  1  result and flags valid.
REQ-010 SHALL have port out_ready  input  1  consumer takes result.
REQ-011 SHALL have port result  output  W  sum or difference.
REQ-012 SHALL have ports overflow, underflow, inexact, invalid  output  1 each  exception flags for current result.

Function
REQ-013 SHALL accept on an edge where in_valid && in_ready; a, b and add_sub_not are sampled only then.
REQ-014 SHALL drive in_ready=1 only in IDLE; one operation in flight at a time.
REQ-015 SHALL have FSM states IDLE, ALIGN, ADD, NORM, ROUND, DONE.
REQ-016 SHALL take the effective operand b' = b with sign inverted when add_sub_not=0.
REQ-017 SHALL treat exponent 0 as zero, flushing subnormal inputs to signed zero.
REQ-018 SHALL handle special inputs with IDLE->DONE in one edge: any NaN -> canonical qNaN (sign 0, exponent all ones, fraction MSB 1, rest 0), invalid=1; +Inf+(-Inf) -> qNaN, invalid=1; one Inf -> that Inf; b' zero -> a; a zero -> b'; both zero -> +0 unless both signs negative.
REQ-019 SHALL otherwise enter ALIGN, loading the shift count d = min(|ea-eb|, MAN_W+3) and setting result exponent to max(ea,eb).
REQ-020 SHALL in ALIGN right-shift the smaller mantissa, hidden 1 included, one bit per cycle with guard/round/sticky capture, and leave after d+1 cycles.
REQ-021 SHALL in ADD add mantissas for equal signs and subtract the smaller magnitude for unequal signs (sign of larger), taking 1 cycle.
REQ-022 SHALL on an exact-zero difference go ADD->DONE with result +0 and all flags 0.
REQ-023 SHALL in NORM right-shift once with exponent+1 on carry-out (1 cycle); otherwise left-shift one bit per cycle until the hidden bit is 1, decrementing the exponent (n shifts, n+1 cycles).
REQ-024 SHALL in ROUND apply round-to-nearest-even using guard/round/sticky in 1 cycle, renormalising on mantissa carry; inexact=1 when any discarded bit is nonzero.
REQ-025 SHALL on an exponent reaching all ones yield signed Inf with overflow=1 and inexact=1.
REQ-026 SHALL on an exponent falling below 1 yield signed zero with underflow=1 and inexact=1.
REQ-027 SHALL give an accept-to-out_valid latency of d+n+4 edges for the general path, d+2 edges for a zero result and 1 edge for special inputs.
REQ-028 SHALL in DONE hold out_valid=1 and keep result and flags stable until out_ready=1, then return to IDLE on that edge.
REQ-029 SHALL keep in_ready=0 in DONE, so a same-cycle out_ready and in_valid pair is accepted one edge later.

Reset
REQ-030 SHALL on rst=1 immediately force IDLE, in_ready=1, out_valid=0, result=0 and all flags 0, regardless of the current state.
REQ-031 SHALL abandon any in-flight operation on reset mid-operation and produce no output for it after reset release.

Verification
REQ-032 SHALL cover: 0x3F800000 + 0x3F800000 -> 0x40000000 after 4 edges, all flags 0.
REQ-033 SHALL cover: 0x3F800000 + 0x33800000 (d=24, tie) -> 0x3F800000, inexact=1, after 28 edges.
REQ-034 SHALL cover: 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000, overflow=1, inexact=1.
REQ-035 SHALL cover: 0x7F800000 sub 0x7F800000 -> 0x7FC00000, invalid=1, out_valid 1 edge after accept.
REQ-036 SHALL cover: 0x00800000 sub 0x00800001 -> 0x80000000, underflow=1, inexact=1; then 0x40400000 sub 0x40400000 -> 0x00000000 after 2 edges.
REQ-037 SHALL cover: out_ready held low 5 cycles in DONE keeps result stable and in_ready=0; rst pulsed in ALIGN gives out_valid=0 and in_ready=1 immediately.
